// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte in, LSB-first frame out, paced entirely by baud_tick.
// Optional parity bit compiled in when UART_TX_PARITY_EN is defined (sense from PARITY_ODD).
`timescale 1ns/1ps
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_tx: illegal parameter value");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, ARM, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP} state_t;
`endif

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   stop_q, stop_d;
  logic                   tx_d, ready_d, busy_d, done_d;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      stop_q   <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      tx       <= tx_d;
      tx_ready <= ready_d;
      tx_busy  <= busy_d;
      tx_done  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Every output is computed here and registered above; the data shifts right so bit 0 is always next.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    tx_d    = tx;
    ready_d = tx_ready;
    busy_d  = tx_busy;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (tx_valid && tx_ready) begin
          sh_d    = tx_data[DATA_BITS-1:0];
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data[DATA_BITS-1:0]) ^ (PARITY_ODD != 0);
`endif
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ARM;
        end
      end
      ARM: if (baud_tick) begin
        tx_d    = 1'b0;
        state_d = START;
      end
      START: if (baud_tick) begin
        tx_d    = sh_q[0];
        sh_d    = sh_q >> 1;
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: if (baud_tick) begin
        if (cnt_q != LAST_BIT) begin
          cnt_d = cnt_q + 3'd1;
          tx_d  = sh_q[0];
          sh_d  = sh_q >> 1;
        end else begin
`ifdef UART_TX_PARITY_EN
          tx_d    = par_q;
          state_d = PARITY;
`else
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_tick) begin
        tx_d    = 1'b1;
        stop_d  = 1'b0;
        state_d = STOP;
      end
`endif
      STOP: if (baud_tick) begin
        if (stop_q == LAST_STOP) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          stop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: an 8N1 instance and a 5-data/2-stop/odd instance share one baud tick.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int N = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data = '0;
  logic       valid8 = 1'b0, valid5 = 1'b0;
  logic       tx8, ready8, busy8, done8;
  logic       tx5, ready5, busy5, done5;
  logic       tx_s, ready_s, busy_s, done_s;
  bit         sel = 1'b0;
  int         tick_cnt = 0;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_cnt  <= (tick_cnt == N - 1) ? 0 : tick_cnt + 1;
    baud_tick <= (tick_cnt == N - 1);
  end

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(valid8),
    .tx_ready(ready8), .tx(tx8), .tx_busy(busy8), .tx_done(done8));

  uart_tx #(.DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(valid5),
    .tx_ready(ready5), .tx(tx5), .tx_busy(busy5), .tx_done(done5));

  assign tx_s    = sel ? tx5    : tx8;
  assign ready_s = sel ? ready5 : ready8;
  assign busy_s  = sel ? busy5  : busy8;
  assign done_s  = sel ? done5  : done8;

  function automatic int nbits(bit s);
    return s ? 5 : 8;
  endfunction

  function automatic int frame_len(bit s);
    return 1 + nbits(s) + P + (s ? 2 : 1);
  endfunction

  // Bit i of the frame on the wire: start, data LSB first, optional parity, stop bits.
  function automatic logic exp_bit(bit s, logic [7:0] d, int i);
    int nb;
    int ones;
    nb = nbits(s);
    if (i == 0) return 1'b0;
    if (i <= nb) return d[i-1];
    if (P == 1 && i == nb + 1) begin
      ones = 0;
      for (int k = 0; k < nb; k++) ones += int'(d[k]);
      return logic'((ones % 2) ^ (s ? 1 : 0));
    end
    return 1'b1;
  endfunction

  task automatic wait_accept(input bit s, input string name);
    bit ok;
    logic r;
    ok  = 1'b0;
    sel = s;
    for (int i = 0; i < 4 * N; i++) begin
      r = ready_s;
      @(negedge clk);
      if (r === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok || ready_s !== 1'b0 || busy_s !== 1'b1) begin
      n_err++;
      $display("FAIL %s_accept: accepted=%b ready=%b busy=%b, required 1 0 1", name, ok, ready_s, busy_s);
    end
  endtask

  // Starts at the accept negedge; ends on the negedge showing tx_done.
  task automatic check_frame(input bit s, input logic [7:0] d, input string name,
                             input int lat_min, input int lat_max, input bit scramble);
    int len;
    int w;
    sel = s;
    len = frame_len(s);
    w   = 0;
    while (tx_s !== 1'b0 && w < 3 * N) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (tx_s !== 1'b0 || w < lat_min || w > lat_max) begin
      n_err++;
      $display("FAIL %s_start: tx=%b after %0d clocks, required 0 after %0d..%0d clocks",
               name, tx_s, w, lat_min, lat_max);
      if (tx_s !== 1'b0) return;
    end
    for (int b = 0; b < len; b++) begin
      logic e;
      int bad;
      int side;
      e    = exp_bit(s, d, b);
      bad  = 0;
      side = 0;
      for (int c = 0; c < N; c++) begin
        if (scramble && c == 0) tx_data = 8'($urandom);
        if (tx_s !== e) bad++;
        if (done_s !== 1'b0 || busy_s !== 1'b1) side++;
        @(negedge clk);
      end
      n_vec++;
      if (bad != 0 || side != 0) begin
        n_err++;
        $display("FAIL %s_bit%0d: tx wrong on %0d/%0d clocks (required %b), done/busy wrong on %0d clocks",
                 name, b, bad, N, e, side);
      end
    end
    n_vec++;
    if (done_s !== 1'b1 || busy_s !== 1'b0 || ready_s !== 1'b1 || tx_s !== 1'b1) begin
      n_err++;
      $display("FAIL %s_end: done=%b busy=%b ready=%b tx=%b, required 1 0 1 1",
               name, done_s, busy_s, ready_s, tx_s);
    end
  endtask

  task automatic send(input bit s, input logic [7:0] d, input string name);
    tx_data = d;
    if (s) valid5 = 1'b1; else valid8 = 1'b1;
    wait_accept(s, name);
    valid5 = 1'b0;
    valid8 = 1'b0;
    check_frame(s, d, name, 1, N + 1, 1'b1);
  endtask

  task automatic idle_gap(input int max_clk);
    int g;
    g = $urandom_range(max_clk, 0);
    for (int i = 0; i < g; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0 || ready8 !== 1'b0 || done8 !== 1'b0 || tx5 !== 1'b1 || busy5 !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold%0d: tx=%b busy=%b ready=%b done=%b, required 1 0 0 0", i, tx8, busy8, ready8, done8);
      end
    end
    rst_n = 1'b1;
    n_vec++;
    if (ready8 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_ready: ready=%b, required 0", ready8);
    end
    @(negedge clk);
    n_vec++;
    if (ready8 !== 1'b1 || ready5 !== 1'b1 || tx8 !== 1'b1 || busy8 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready_rise: ready8=%b ready5=%b tx=%b busy=%b, required 1 1 1 0", ready8, ready5, tx8, busy8);
    end
  endtask

  task automatic test_single();
    idle_gap(N);
    send(1'b0, 8'hA5, "single_a5");
    @(negedge clk);
    n_vec++;
    if (done8 !== 1'b0 || ready8 !== 1'b1 || tx8 !== 1'b1) begin
      n_err++;
      $display("FAIL single_done_pulse: done=%b ready=%b tx=%b, required 0 1 1", done8, ready8, tx8);
    end
  endtask

  task automatic test_parity();
    idle_gap(N);
    send(1'b0, 8'h07, "parity_even");
    idle_gap(N);
    send(1'b1, 8'h07, "parity_odd");
  endtask

  task automatic test_five_bits();
    idle_gap(N);
    send(1'b1, 8'h1F, "five_1f");
    idle_gap(N);
    send(1'b1, 8'hE0, "five_e0");
  endtask

  task automatic test_back_to_back();
    logic r;
    idle_gap(N);
    sel     = 1'b0;
    tx_data = 8'h55;
    valid8  = 1'b1;
    wait_accept(1'b0, "b2b_first");
    tx_data = 8'hAA;
    check_frame(1'b0, 8'h55, "b2b_55", 1, N + 1, 1'b0);
    r = ready8;
    @(negedge clk);
    n_vec++;
    if (r !== 1'b1 || ready8 !== 1'b0 || busy8 !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second_accept: ready_before=%b ready=%b busy=%b, required 1 0 1", r, ready8, busy8);
    end
    valid8 = 1'b0;
    check_frame(1'b0, 8'hAA, "b2b_aa", N - 1, N - 1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int w;
    idle_gap(N);
    tx_data = 8'($urandom);
    valid8  = 1'b1;
    wait_accept(1'b0, "midrst");
    valid8 = 1'b0;
    w = 0;
    while (tx8 !== 1'b0 && w < 3 * N) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 4 * N + 3; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (tx8 !== 1'b1 || ready8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_outputs: tx=%b ready=%b busy=%b done=%b, required 1 0 0 0", tx8, ready8, busy8, done8);
    end
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (done8 !== 1'b0 || tx8 !== 1'b1) begin
        n_vec++;
        n_err++;
        $display("FAIL midrst_hold: done=%b tx=%b, required 0 1", done8, tx8);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    send(1'b0, 8'h3C, "midrst_3c");
  endtask

  task automatic test_random();
    bit s;
    logic [7:0] d;
    for (int i = 0; i < 12; i++) begin
      s = 1'($urandom_range(1, 0));
      d = 8'($urandom);
      idle_gap(2 * N);
      send(s, d, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_five_bits();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the Latch register-access path. Accepts one byte at a time over a valid/ready handshake and shifts it onto the `tx` line LSB-first. The frame is a start bit, the data bits, an optional parity bit and one or two stop bits. The transmitter sits directly downstream of the baud tick generator: every bit period is bounded by consecutive `baud_tick` pulses, and the transmitter never counts clocks itself.

## Interface
- `DATA_BITS`, default 8: data bits per frame. Legal values are 5..8. Only `tx_data[DATA_BITS-1:0]` is sent.
- `STOP_BITS`, default 1: stop bits per frame. Legal values are 1 or 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Has effect only when `UART_TX_PARITY_EN` is defined.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `baud_tick`  in  1  one-cycle pulse, once per bit period, from the baud tick generator.
- `tx_data`  in  8  byte to transmit; sampled on accept.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  transmitter can accept a byte.
- `tx`  out  1  serial line; idles high.
- `tx_busy`  out  1  a frame is in progress (accepted and not yet finished).
- `tx_done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- States:
  - IDLE
  - ARM
  - START
  - DATA
  - PARITY (exists only when `UART_TX_PARITY_EN` is defined)
  - STOP
- Accept rule: a byte is accepted on a rising edge where `tx_valid && tx_ready`. On that edge:
  - `tx_data` is copied into a shift register.
  - The parity bit is computed: XOR of the data bits, inverted if `PARITY_ODD`=1.
  - State goes IDLE→ARM.
- ARM: `tx` stays 1. On the first `baud_tick` seen in ARM, `tx` is set to 0 and state goes to START.
  - A tick that coincides with the accept edge is not used, because the state is still IDLE on that edge.
- START, on `baud_tick`: `tx` is set to data bit 0, the bit counter is cleared, and state goes to DATA.
- DATA, on `baud_tick`:
  - If bit counter < `DATA_BITS`-1: increment the counter and set `tx` to the next data bit.
  - Otherwise, go to PARITY with `tx` set to the parity bit, or, without parity, go to STOP with `tx` set to 1.
- PARITY, on `baud_tick`: `tx` is set to 1 and state goes to STOP.
- STOP: count `STOP_BITS` ticks. On the final tick:
  - Pulse `tx_done`.
  - Set `tx_ready` to 1.
  - Go to IDLE.
  - `tx` remains 1.
- Without a `baud_tick` the FSM holds its state indefinitely; there is no timeout.
- `tx_valid` or `tx_data` changing while the transmitter is not ready is ignored. The registered copy of the byte is what gets sent.
- Bit counter width is 3 bits; it never wraps within a legal frame.

## Timing
- All outputs are registered.
- Values while `rst_n`=0:
  - `tx`=1
  - `tx_ready`=0
  - `tx_busy`=0
  - `tx_done`=0
  - state is IDLE
- `tx_ready` rises on the first clock edge after `rst_n` deasserts.
- On the accept edge, `tx_ready` goes 0 and `tx_busy` goes 1.
- `tx` changes only on edges where `baud_tick`=1. Each bit therefore lasts exactly one tick interval: N clocks, where N is the generator period.
- Start-bit latency after accept: from 1 up to N+1 clocks, depending on the tick phase.
- Frame length from the start-bit falling edge to `tx_done` is (1 + `DATA_BITS` + P + `STOP_BITS`) × N clocks, where P=1 with parity and P=0 without.
- On the `tx_done` edge, `tx_busy` goes 0 and `tx_ready` goes 1.
- Back-to-back transfers:
  - The next accept can happen on the cycle after `tx_done`.
  - The next start bit then begins at the following tick, so there is exactly one idle-high bit period at minimum.
- Reset asserted mid-frame: all outputs immediately take their reset values (`tx` returns to 1) and the byte in progress is discarded. No `tx_done` is produced.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state and the parity register are compiled in.
  - A parity bit is sent after the data bits, with sense set by `PARITY_ODD`.
- `UART_TX_PARITY_EN` undefined:
  - No parity logic exists and DATA goes straight to STOP.
  - `PARITY_ODD` is ignored.

## Test plan
- Reset release: hold `rst_n`=0 for 5 clocks, then release. Require `tx`=1 and `tx_busy`=0 throughout, and `tx_ready`=1 one clock after release.
- Single byte, defaults, N=10 (100 MHz clock, 10 Mbaud): send 0xA5. Require bits on `tx` of 0,1,0,1,0,0,1,0,1,1, each lasting exactly 10 clocks. Require `tx_done` to pulse once, at the end of the stop bit.
- Parity with `UART_TX_PARITY_EN` defined: 0x07 with `PARITY_ODD`=0 gives parity bit 1; with `PARITY_ODD`=1 it gives 0. The frame is 11 bit periods.
- `DATA_BITS`=5, `STOP_BITS`=2: send 0x1F. Require start bit 0, then 1,1,1,1,1, then two stop bits of 1 each, with `tx_done` after 8 periods. Bits 7:5 of `tx_data` are never sent.
- Back-to-back: hold `tx_valid`=1 with 0x55 and then 0xAA. Require a second accept on the cycle after `tx_done` and exactly one idle bit period between the frames. Changing `tx_data` while `tx_ready`=0 must not corrupt the frame.
- Reset mid-frame: assert `rst_n`=0 during data bit 3. Require `tx`=1 immediately with no `tx_done`. After release, a new byte 0x3C transmits correctly.
